prefetch_mem_arbiter: RTL and testbench
=======================================

Name: prefetch_mem_arbiter

Overview:
- Sequences the prefetch path of the prefetch cache and shares the single cacheline adapter between demand misses/writebacks and next-line prefetches.
- Accepts prefetch triggers from the cache and computes the next-line target.
- Fetches that line when the memory port is idle and delivers it back to the cache as a one-cycle prefetch_ready pulse.
- Demand traffic always has priority over prefetch traffic that has not yet been issued.

Parameters:
- s_offset, 5, byte-offset bits per line; line size = 2**s_offset bytes.
- s_line, 256, line width in bits (8*2**s_offset).
- CNT_WIDTH, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- dmd_read  in  1  cache demand line read; held until dmd_resp.
- dmd_write  in  1  cache demand line write (writeback); held until dmd_resp.
- dmd_address  in  32  demand line address (low s_offset bits zero).
- dmd_wdata  in  s_line  demand write data.
- dmd_rdata  out  s_line  demand read data; equals pmem_rdata.
- dmd_resp  out  1  demand complete.
- prefetch_start  in  1  one-cycle trigger from cache.
- cacheline_address  in  32  line address that caused the trigger.
- cache_way  in  1  way chosen by the cache for the prefetched line.
- prefetch_rdata  out  s_line  prefetched line.
- prefetch_ready  out  1  one-cycle delivery pulse.
- pf_cline_address  out  32  address of the delivered line.
- pf_cache_way  out  1  way tag returned with the delivered line.
- pmem_read / pmem_write  out  1  requests to the cacheline adapter.
- pmem_address  out  32  memory address.
- pmem_wdata  out  s_line  memory write data.
- pmem_rdata  in  s_line  memory read data.
- pmem_resp  in  1  memory transaction complete.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; pending, buffer-valid and last-delivered-valid flags are cleared.
  - All outputs are 0: pmem_read, pmem_write, dmd_resp, prefetch_ready, pmem_address, pmem_wdata, prefetch_rdata, pf_cline_address, pf_cache_way.
  - Reset during an in-flight memory transaction abandons it; a late pmem_resp after reset is ignored in IDLE.
- Target computation:
  - target = {cacheline_address[31:s_offset] + 1, s_offset'b0}, using s_offset-wide zero fill.
  - If cacheline_address[31:s_offset] is all ones (the increment would wrap to 0x00000000), the trigger is dropped.
- Pending register (single entry: target and way):
  - Loaded on prefetch_start unless the trigger is filtered or the FSM is in PF_FETCH.
  - A newer trigger overwrites an unissued pending entry (latest wins).
  - Triggers arriving during PF_FETCH are dropped.
  - Duplicate filter: a trigger is dropped if its target equals the last delivered pf_cline_address (last-delivered valid).
- FSM states: IDLE, DEMAND, PF_FETCH, PF_DELIVER.
  - IDLE:
    - If dmd_read or dmd_write is asserted, go to DEMAND.
    - Otherwise, if pending is valid, go to PF_FETCH and clear pending.
    - Demand wins when both are present in the same cycle.
  - DEMAND:
    - pmem_read/pmem_write mirror dmd_read/dmd_write; pmem_address = dmd_address; pmem_wdata = dmd_wdata.
    - pmem_* are registered: they assert the cycle after leaving IDLE.
    - On pmem_resp: dmd_resp = 1 in the same cycle (combinational), dmd_rdata = pmem_rdata, go to IDLE.
    - Next-request turnaround is 1 cycle minimum.
  - PF_FETCH:
    - pmem_read = 1 and pmem_address = target, held until pmem_resp.
    - The fetch is not abortable; demand requests stall until it completes.
    - On pmem_resp: capture pmem_rdata into the buffer, go to PF_DELIVER.
  - PF_DELIVER:
    - prefetch_ready = 1 for exactly one cycle, with prefetch_rdata, pf_cline_address and pf_cache_way valid.
    - Record last-delivered address, then go to IDLE.
- Stale cancel: if a demand write completes to a line equal to the pending target, the pending entry is cleared.
- Latency:
  - Demand: pmem_read rises 1 cycle after the request is seen in IDLE; dmd_resp coincides with pmem_resp.
  - Prefetch: prefetch_ready rises 1 cycle after the PF_FETCH pmem_resp.
- pmem_read and pmem_write are never asserted together; at most one pmem transaction is outstanding.

Optional Feature:
- Macro: PREFETCH_ARB_STATS_EN.
- When defined, three extra outputs (CNT_WIDTH each) are added:
  - pf_issued_cnt: increments on every PF_FETCH entry.
  - pf_dropped_cnt: increments on every filtered, wrapped, overwritten or PF_FETCH-dropped trigger, and on every stale-cancelled pending entry.
  - dmd_stall_cnt: increments each cycle a demand request is held while the FSM is in PF_FETCH or PF_DELIVER.
- Counters reset to 0 and saturate at all-ones.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then IDLE; prefetch_start with cacheline_address=0x00001040, cache_way=1 -> pmem_read with pmem_address=0x00001060; after pmem_resp (pmem_rdata=D), a 1-cycle prefetch_ready with prefetch_rdata=D, pf_cline_address=0x00001060, pf_cache_way=1.
- dmd_read at 0x2000 in the same cycle prefetch_start(0x3000) is loaded -> demand served first (pmem_address=0x2000, dmd_resp with pmem_resp); then prefetch of 0x3020 issued.
- prefetch_start at 0xFFFFFFE0 -> no pmem activity and no prefetch_ready; repeat trigger at 0x00001040 after delivering 0x1060 -> dropped (duplicate filter).
- Demand write to 0x5020 completes while pending target=0x5020 -> pending cleared; no pmem_read of 0x5020 follows.
- rst=0 asserted mid-PF_FETCH, then a pmem_resp pulse after release -> all outputs 0 and no prefetch_ready.
- With PREFETCH_ARB_STATS_EN: dmd_read held during a 4-cycle PF_FETCH -> dmd_stall_cnt=4, pf_issued_cnt=1.

Source files
------------

// File: rtl/prefetch_mem_arbiter.sv
// Next-line prefetch sequencer sharing one cacheline adapter between demand traffic and prefetches.
// Optional statistics counters are enabled by defining PREFETCH_ARB_STATS_EN.
module prefetch_mem_arbiter #(
  parameter int s_offset = 5,
  parameter int s_line   = 8 * (2 ** s_offset)
`ifdef PREFETCH_ARB_STATS_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmd_read,
  input  logic              dmd_write,
  input  logic [31:0]       dmd_address,
  input  logic [s_line-1:0] dmd_wdata,
  output logic [s_line-1:0] dmd_rdata,
  output logic              dmd_resp,
  input  logic              prefetch_start,
  input  logic [31:0]       cacheline_address,
  input  logic              cache_way,
  output logic [s_line-1:0] prefetch_rdata,
  output logic              prefetch_ready,
  output logic [31:0]       pf_cline_address,
  output logic              pf_cache_way,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef PREFETCH_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] pf_issued_cnt,
  output logic [CNT_WIDTH-1:0] pf_dropped_cnt,
  output logic [CNT_WIDTH-1:0] dmd_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, DEMAND, PF_FETCH, PF_DELIVER} state_e;

  localparam logic [31:0] OFF_MASK = 32'((64'd1 << s_offset) - 64'd1);

  state_e              state_q, state_d;
  logic                pmem_read_q, pmem_read_d;
  logic                pmem_write_q, pmem_write_d;
  logic [31:0]         pmem_address_q, pmem_address_d;
  logic [s_line-1:0]   pmem_wdata_q, pmem_wdata_d;
  logic [s_line-1:0]   buf_q, buf_d;
  logic                buf_vld_q, buf_vld_d;
  logic [31:0]         pf_addr_q, pf_addr_d;
  logic                pf_way_q, pf_way_d;
  logic [31:0]         last_addr_q, last_addr_d;
  logic                last_vld_q, last_vld_d;
  logic                pend_vld_q, pend_vld_d;
  logic [31:0]         pend_target_q, pend_target_d;
  logic                pend_way_q, pend_way_d;

  logic [31:0] trig_fill, trig_target;
  logic        trig_wrap, trig_dup, trig_accept;
  logic        pf_issue, stale_cancel, overwrite;

  // Filling the offset bits with ones lets the +1 carry into the line index and exposes wrap as all-ones.
  assign trig_fill   = cacheline_address | OFF_MASK;
  assign trig_wrap   = &trig_fill;
  assign trig_target = trig_fill + 32'd1;
  assign trig_dup    = (last_vld_q && (trig_target == last_addr_q)) ||
                       ((state_q == PF_DELIVER) && (trig_target == pf_addr_q));
  assign trig_accept = prefetch_start && !trig_wrap && !trig_dup && (state_q != PF_FETCH);

  assign stale_cancel = (state_q == DEMAND) && pmem_resp && pmem_write_q &&
                        pend_vld_q && (pmem_address_q == pend_target_q);

  assign pmem_read        = pmem_read_q;
  assign pmem_write       = pmem_write_q;
  assign pmem_address     = pmem_address_q;
  assign pmem_wdata       = pmem_wdata_q;
  assign dmd_rdata        = pmem_rdata;
  assign prefetch_rdata   = buf_q;
  assign pf_cline_address = pf_addr_q;
  assign pf_cache_way     = pf_way_q;

  always_comb begin
    state_d        = state_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    buf_d          = buf_q;
    buf_vld_d      = buf_vld_q;
    pf_addr_d      = pf_addr_q;
    pf_way_d       = pf_way_q;
    last_addr_d    = last_addr_q;
    last_vld_d     = last_vld_q;
    pf_issue       = 1'b0;
    dmd_resp       = 1'b0;
    prefetch_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmd_read || dmd_write) begin
          state_d        = DEMAND;
          pmem_read_d    = dmd_read;
          pmem_write_d   = dmd_write && !dmd_read;
          pmem_address_d = dmd_address;
          pmem_wdata_d   = dmd_wdata;
        end else if (pend_vld_q) begin
          state_d        = PF_FETCH;
          pf_issue       = 1'b1;
          pmem_read_d    = 1'b1;
          pmem_address_d = pend_target_q;
          pf_addr_d      = pend_target_q;
          pf_way_d       = pend_way_q;
        end
      end
      DEMAND: begin
        if (pmem_resp) begin
          dmd_resp     = 1'b1;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = IDLE;
        end
      end
      PF_FETCH: begin
        if (pmem_resp) begin
          buf_d       = pmem_rdata;
          buf_vld_d   = 1'b1;
          pmem_read_d = 1'b0;
          state_d     = PF_DELIVER;
        end
      end
      PF_DELIVER: begin
        prefetch_ready = buf_vld_q;
        buf_vld_d      = 1'b0;
        last_addr_d    = pf_addr_q;
        last_vld_d     = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue and stale-cancel clear first so a same-cycle trigger still lands as the newest entry.
  always_comb begin
    pend_vld_d    = pend_vld_q;
    pend_target_d = pend_target_q;
    pend_way_d    = pend_way_q;
    overwrite     = 1'b0;
    if (pf_issue || stale_cancel) pend_vld_d = 1'b0;
    if (trig_accept) begin
      overwrite     = pend_vld_d;
      pend_vld_d    = 1'b1;
      pend_target_d = trig_target;
      pend_way_d    = cache_way;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      buf_q          <= '0;
      buf_vld_q      <= 1'b0;
      pf_addr_q      <= '0;
      pf_way_q       <= 1'b0;
      last_addr_q    <= '0;
      last_vld_q     <= 1'b0;
      pend_vld_q     <= 1'b0;
      pend_target_q  <= '0;
      pend_way_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      buf_q          <= buf_d;
      buf_vld_q      <= buf_vld_d;
      pf_addr_q      <= pf_addr_d;
      pf_way_q       <= pf_way_d;
      last_addr_q    <= last_addr_d;
      last_vld_q     <= last_vld_d;
      pend_vld_q     <= pend_vld_d;
      pend_target_q  <= pend_target_d;
      pend_way_q     <= pend_way_d;
    end
  end

`ifdef PREFETCH_ARB_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH + 1)'(inc);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0] issued_q, dropped_q, stall_q;
  logic [1:0]           drop_inc;
  logic                 stall_now;

  assign drop_inc  = 2'(prefetch_start && !trig_accept) + 2'(overwrite) + 2'(stale_cancel);
  assign stall_now = (dmd_read || dmd_write) && ((state_q == PF_FETCH) || (state_q == PF_DELIVER));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q  <= '0;
      dropped_q <= '0;
      stall_q   <= '0;
    end else begin
      issued_q  <= sat_add(issued_q, {1'b0, pf_issue});
      dropped_q <= sat_add(dropped_q, drop_inc);
      stall_q   <= sat_add(stall_q, {1'b0, stall_now});
    end
  end

  assign pf_issued_cnt  = issued_q;
  assign pf_dropped_cnt = dropped_q;
  assign dmd_stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_prefetch_mem_arbiter.sv
// Directed bench for prefetch_mem_arbiter: demand priority, next-line prefetch, filters and reset.
module tb_prefetch_mem_arbiter;
  localparam int SL = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dmd_read = 1'b0, dmd_write = 1'b0;
  logic [31:0]   dmd_address = '0;
  logic [SL-1:0] dmd_wdata = '0;
  logic [SL-1:0] dmd_rdata;
  logic          dmd_resp;
  logic          prefetch_start = 1'b0;
  logic [31:0]   cacheline_address = '0;
  logic          cache_way = 1'b0;
  logic [SL-1:0] prefetch_rdata;
  logic          prefetch_ready;
  logic [31:0]   pf_cline_address;
  logic          pf_cache_way;
  logic          pmem_read, pmem_write;
  logic [31:0]   pmem_address;
  logic [SL-1:0] pmem_wdata;
  logic [SL-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
`ifdef PREFETCH_ARB_STATS_EN
  logic [15:0]   pf_issued_cnt, pf_dropped_cnt, dmd_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  prefetch_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .dmd_read(dmd_read), .dmd_write(dmd_write), .dmd_address(dmd_address),
    .dmd_wdata(dmd_wdata), .dmd_rdata(dmd_rdata), .dmd_resp(dmd_resp),
    .prefetch_start(prefetch_start), .cacheline_address(cacheline_address),
    .cache_way(cache_way), .prefetch_rdata(prefetch_rdata), .prefetch_ready(prefetch_ready),
    .pf_cline_address(pf_cline_address), .pf_cache_way(pf_cache_way),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef PREFETCH_ARB_STATS_EN
    , .pf_issued_cnt(pf_issued_cnt), .pf_dropped_cnt(pf_dropped_cnt), .dmd_stall_cnt(dmd_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pmem_read(output logic found);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (pmem_read === 1'b1) found = 1'b1;
    end
  endtask

  task automatic watch_quiet(input int n, output logic active);
    active = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || prefetch_ready !== 1'b0) active = 1'b1;
    end
  endtask

  task automatic pulse_trigger(input logic [31:0] a, input logic w);
    prefetch_start = 1'b1; cacheline_address = a; cache_way = w;
    tick();
    prefetch_start = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    tick(); tick();
    tests++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin fails++; $display("FAIL reset_pmem_req: rd=%b wr=%b expected 0", pmem_read, pmem_write); end
    tests++; if (dmd_resp !== 1'b0 || prefetch_ready !== 1'b0) begin fails++; $display("FAIL reset_resp: dmd_resp=%b ready=%b expected 0", dmd_resp, prefetch_ready); end
    tests++; if (pmem_address !== 32'h0 || pf_cline_address !== 32'h0 || pf_cache_way !== 1'b0) begin fails++; $display("FAIL reset_addr: pmem=%h pf=%h way=%b expected 0", pmem_address, pf_cline_address, pf_cache_way); end
    tests++; if (pmem_wdata !== '0 || prefetch_rdata !== '0) begin fails++; $display("FAIL reset_data: wdata=%h rdata=%h expected 0", pmem_wdata, prefetch_rdata); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_prefetch_basic();
    logic found;
    logic [SL-1:0] d;
    d = {8{32'hCAFE_0001}};
    pulse_trigger(32'h0000_1040, 1'b1);
    wait_pmem_read(found);
    tests++; if (!found) begin fails++; $display("FAIL pf_issue: pmem_read never rose, expected 1"); end
    tests++; if (pmem_address !== 32'h0000_1060 || pmem_write !== 1'b0) begin fails++; $display("FAIL pf_target: addr=%h wr=%b expected 00001060/0", pmem_address, pmem_write); end
    pmem_rdata = d; pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    tests++; if (prefetch_ready !== 1'b1 || pmem_read !== 1'b0) begin fails++; $display("FAIL pf_ready: ready=%b rd=%b expected 1/0", prefetch_ready, pmem_read); end
    tests++; if (prefetch_rdata !== d) begin fails++; $display("FAIL pf_rdata: got %h expected %h", prefetch_rdata, d); end
    tests++; if (pf_cline_address !== 32'h0000_1060 || pf_cache_way !== 1'b1) begin fails++; $display("FAIL pf_tag: addr=%h way=%b expected 00001060/1", pf_cline_address, pf_cache_way); end
    tick();
    tests++; if (prefetch_ready !== 1'b0) begin fails++; $display("FAIL pf_pulse_width: ready=%b expected 0", prefetch_ready); end
  endtask

  task automatic test_duplicate();
    logic active;
    pulse_trigger(32'h0000_1040, 1'b0);
    watch_quiet(6, active);
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL dup_filter: activity=%b expected 0", active); end
  endtask

  task automatic test_demand_priority();
    logic found;
    logic [SL-1:0] e;
    e = {8{32'h1234_5678}};
    dmd_read = 1'b1; dmd_address = 32'h0000_2000;
    pulse_trigger(32'h0000_3000, 1'b0);
    tests++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_2000) begin fails++; $display("FAIL dmd_first: rd=%b wr=%b addr=%h expected 1/0/00002000", pmem_read, pmem_write, pmem_address); end
    tick();
    tests++; if (dmd_resp !== 1'b0) begin fails++; $display("FAIL dmd_resp_early: got %b expected 0", dmd_resp); end
    pmem_rdata = e; pmem_resp = 1'b1;
    #1;
    tests++; if (dmd_resp !== 1'b1 || dmd_rdata !== e) begin fails++; $display("FAIL dmd_resp: resp=%b rdata=%h expected 1/%h", dmd_resp, dmd_rdata, e); end
    tick();
    dmd_read = 1'b0; pmem_resp = 1'b0;
    wait_pmem_read(found);
    tests++; if (!found || pmem_address !== 32'h0000_3020) begin fails++; $display("FAIL pf_after_dmd: found=%b addr=%h expected 1/00003020", found, pmem_address); end
    pmem_rdata = ~e; pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    tests++; if (prefetch_ready !== 1'b1 || pf_cline_address !== 32'h0000_3020 || pf_cache_way !== 1'b0 || prefetch_rdata !== ~e) begin fails++; $display("FAIL pf_after_dmd_deliver: ready=%b addr=%h way=%b expected 1/00003020/0", prefetch_ready, pf_cline_address, pf_cache_way); end
    tick();
  endtask

  task automatic test_back_to_back();
    dmd_read = 1'b1; dmd_address = 32'h0000_8000;
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; dmd_address = 32'h0000_8020;
    tests++; if (pmem_read !== 1'b0) begin fails++; $display("FAIL b2b_turnaround: rd=%b expected 0", pmem_read); end
    tick();
    tests++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_8020) begin fails++; $display("FAIL b2b_second: rd=%b addr=%h expected 1/00008020", pmem_read, pmem_address); end
    pmem_resp = 1'b1;
    tick();
    dmd_read = 1'b0; pmem_resp = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic active;
    pulse_trigger(32'hFFFF_FFE0, 1'b1);
    watch_quiet(6, active);
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL wrap_drop: activity=%b expected 0", active); end
  endtask

  task automatic test_stale_cancel();
    logic active;
    logic [SL-1:0] w;
    w = {8{32'h5A5A_0F0F}};
    dmd_write = 1'b1; dmd_address = 32'h0000_5020; dmd_wdata = w;
    pulse_trigger(32'h0000_5000, 1'b0);
    tests++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h0000_5020 || pmem_wdata !== w) begin fails++; $display("FAIL wb_issue: wr=%b rd=%b addr=%h expected 1/0/00005020", pmem_write, pmem_read, pmem_address); end
    pmem_resp = 1'b1;
    #1;
    tests++; if (dmd_resp !== 1'b1) begin fails++; $display("FAIL wb_resp: got %b expected 1", dmd_resp); end
    tick();
    dmd_write = 1'b0; pmem_resp = 1'b0;
    watch_quiet(6, active);
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL stale_cancel: activity=%b expected 0", active); end
  endtask

  task automatic test_reset_mid_fetch();
    logic found;
    logic active;
    pulse_trigger(32'h0000_7000, 1'b1);
    wait_pmem_read(found);
    tests++; if (!found || pmem_address !== 32'h0000_7020) begin fails++; $display("FAIL mid_fetch_issue: found=%b addr=%h expected 1/00007020", found, pmem_address); end
    rst = 1'b0;
    #1;
    tests++; if (pmem_read !== 1'b0 || pmem_address !== 32'h0) begin fails++; $display("FAIL async_reset: rd=%b addr=%h expected 0/0", pmem_read, pmem_address); end
    tick(); tick();
    rst = 1'b1;
    tick();
    pmem_rdata = {8{32'hBAD0_BAD0}}; pmem_resp = 1'b1;
    #1;
    tests++; if (dmd_resp !== 1'b0) begin fails++; $display("FAIL late_resp_dmd: got %b expected 0", dmd_resp); end
    tick();
    pmem_resp = 1'b0;
    tests++; if (prefetch_ready !== 1'b0 || pf_cline_address !== 32'h0 || pf_cache_way !== 1'b0 || prefetch_rdata !== '0) begin fails++; $display("FAIL late_resp_outputs: ready=%b addr=%h way=%b expected 0", prefetch_ready, pf_cline_address, pf_cache_way); end
    watch_quiet(4, active);
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL late_resp_quiet: activity=%b expected 0", active); end
  endtask

`ifdef PREFETCH_ARB_STATS_EN
  task automatic test_stats_stall();
    logic found;
    pulse_trigger(32'h0000_9000, 1'b0);
    wait_pmem_read(found);
    tests++; if (!found) begin fails++; $display("FAIL stats_issue: pmem_read never rose, expected 1"); end
    tick();
    dmd_read = 1'b1; dmd_address = 32'h0000_A000;
    tick(); tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    tick();
    tests++; if (dmd_stall_cnt !== 16'd4) begin fails++; $display("FAIL stats_stall: got %0d expected 4", dmd_stall_cnt); end
    tests++; if (pf_issued_cnt !== 16'd1 || pf_dropped_cnt !== 16'd0) begin fails++; $display("FAIL stats_issued: issued=%0d dropped=%0d expected 1/0", pf_issued_cnt, pf_dropped_cnt); end
    tick();
    tests++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_A000) begin fails++; $display("FAIL stats_dmd_after: rd=%b addr=%h expected 1/0000a000", pmem_read, pmem_address); end
    pmem_resp = 1'b1;
    tick();
    dmd_read = 1'b0; pmem_resp = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_prefetch_basic();
    test_duplicate();
    test_demand_priority();
    test_back_to_back();
    test_wrap();
    test_stale_cancel();
    test_reset_mid_fetch();
`ifdef PREFETCH_ARB_STATS_EN
    test_stats_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
